// File: rtl/pipe_hazard_pkg.sv
// Shared hazard-unit definitions: register width, forward-select constant,
// PC source encoding and the nearest-stage priority helper.
package pipe_hazard_pkg;

  localparam int REG_AW  = 5;
  localparam int MAX_FWD = 16;

  localparam int unsigned FWD_REGFILE = 0;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_t;

  // Bit i of m set means stage i+1 matches; lowest stage is nearest.
  function automatic int unsigned nearest_stage(
    input logic [MAX_FWD-1:0] m
  );
    nearest_stage = FWD_REGFILE;
    for (int i = MAX_FWD - 1; i >= 0; i--) begin
      if (m[i]) nearest_stage = unsigned'(i + 1);
    end
  endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Single-outstanding MDU scoreboard: per-register pending bits, busy flag
// and a saturating watchdog with a sticky timeout flag.
// Ports: i_clk, i_reset (sync, high), i_accept/i_set_rd (issue),
//   i_done/i_done_rd (writeback), i_rs1/i_rs2/i_rd lookups -> o_pend_*,
//   o_busy, o_timeout.
module mdu_scoreboard #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_accept,
  input  logic [AW-1:0] i_set_rd,
  input  logic          i_done,
  input  logic [AW-1:0] i_done_rd,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  input  logic [AW-1:0] i_rd,
  output logic          o_pend_rs1,
  output logic          o_pend_rs2,
  output logic          o_pend_rd,
  output logic          o_busy,
  output logic          o_timeout
);
  import pipe_hazard_pkg::*;

  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(TIMEOUT + 1);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_to;
  logic [CW-1:0]   r_wd_cnt;
  logic [CW-1:0]   w_wd_nxt;
  logic            w_done_eff;
  logic            w_hit;

  always_comb begin
    // A completion with nothing outstanding is stale and ignored.
    w_done_eff    = i_done & r_busy;
    w_pending_nxt = r_pending;
    if (w_done_eff) w_pending_nxt[i_done_rd] = 1'b0;
    // Set after clear: a back-to-back op to the same rd stays pending.
    if (i_accept) w_pending_nxt[i_set_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
    w_busy_nxt = i_accept | (r_busy & ~w_done_eff);
    w_wd_nxt   = r_wd_cnt;
    if (i_accept)
      w_wd_nxt = '0;
    else if (r_busy && (r_wd_cnt != CW'(TIMEOUT)))
      w_wd_nxt = r_wd_cnt + 1'b1;
    // Count reaches TIMEOUT at this edge: flag visible now.
    w_hit = r_busy & (r_wd_cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_wd_cnt  <= '0;
      r_to      <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_busy    <= w_busy_nxt;
      r_wd_cnt  <= w_wd_nxt;
      r_to      <= r_to | w_hit;
    end
  end

  assign o_pend_rs1 = r_pending[i_rs1];
  assign o_pend_rs2 = r_pending[i_rs2];
  assign o_pend_rd  = r_pending[i_rd];
  assign o_busy     = r_busy;
  assign o_timeout  = r_to | w_hit;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard control: forwarding selects, load-use and scoreboard
// stalls, MDU structural stall, redirect/exception flushes.
// Ports: D/E/fwd-stage register info in; stall_*, flush_*, forward_*_e,
//   mdu_busy, mdu_timeout out. reset is synchronous, active-high.
module hazard_scoreboard_unit #(
  parameter int NUM_FWD     = 3,
  parameter int LOAD_READY  = 2,
  parameter int REG_AW      = pipe_hazard_pkg::REG_AW,
  parameter int MDU_TIMEOUT = 64,
  parameter int SEL_W       = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_AW-1:0]        rs1_d,
  input  logic [REG_AW-1:0]        rs2_d,
  input  logic [REG_AW-1:0]        rd_d,
  input  logic                     regwrite_d,
  input  logic [REG_AW-1:0]        rs1_e,
  input  logic [REG_AW-1:0]        rs2_e,
  input  logic [REG_AW-1:0]        rd_e,
  input  logic                     load_e,
  input  logic                     mdu_issue_e,
  input  logic [NUM_FWD*REG_AW-1:0] rd_fwd,
  input  logic [NUM_FWD-1:0]       regwrite_fwd,
  input  logic [NUM_FWD-1:0]       load_fwd,
  input  logic [1:0]               pc_src_e,
  input  logic                     ex_flush,
  input  logic                     mdu_done,
  input  logic [REG_AW-1:0]        mdu_rd_done,
  output logic                     stall_f1,
  output logic                     stall_f2,
  output logic                     stall_d,
  output logic                     stall_e,
  output logic                     flush_f2,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic [NUM_FWD-2:0]       flush_m,
  output logic [SEL_W-1:0]         forward_a_e,
  output logic [SEL_W-1:0]         forward_b_e,
  output logic                     mdu_busy,
  output logic                     mdu_timeout
);
  import pipe_hazard_pkg::*;

  logic [NUM_FWD-1:0] w_match_a;
  logic [NUM_FWD-1:0] w_match_b;
  logic [NUM_FWD-1:0] w_ld_fwd;
  logic [REG_AW-1:0]  w_rdk;
  logic               w_ld_e;
  logic               w_ld_stall;
  logic               w_sb_stall;
  logic               w_d_stall;
  logic               w_stall_e;
  logic               w_accept;
  logic               w_redir;
  logic               w_front;
  logic               w_pend_rs1;
  logic               w_pend_rs2;
  logic               w_pend_rd;
  logic               w_busy;
  logic [SEL_W-1:0]   w_fwd_a;
  logic [SEL_W-1:0]   w_fwd_b;

  always_comb begin
    w_match_a = '0;
    w_match_b = '0;
    w_ld_fwd  = '0;
    w_rdk     = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      w_rdk = rd_fwd[k*REG_AW +: REG_AW];
      w_match_a[k] = regwrite_fwd[k] && (w_rdk == rs1_e)
                     && (rs1_e != '0);
      w_match_b[k] = regwrite_fwd[k] && (w_rdk == rs2_e)
                     && (rs2_e != '0);
      // Slice k is stage k+1; loads there before LOAD_READY lack data.
      w_ld_fwd[k]  = (k < LOAD_READY - 1) && load_fwd[k]
                     && regwrite_fwd[k] && (w_rdk != '0)
                     && ((w_rdk == rs1_d) || (w_rdk == rs2_d));
    end
  end

  assign w_fwd_a = SEL_W'(nearest_stage(MAX_FWD'(w_match_a)));
  assign w_fwd_b = SEL_W'(nearest_stage(MAX_FWD'(w_match_b)));

  assign w_ld_e = load_e && (rd_e != '0)
                  && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign w_ld_stall = w_ld_e | (|w_ld_fwd);
  assign w_sb_stall = w_pend_rs1 | w_pend_rs2
                      | (regwrite_d & w_pend_rd);
  assign w_d_stall  = w_ld_stall | w_sb_stall;

  assign w_stall_e = mdu_issue_e & w_busy & ~mdu_done & ~ex_flush;
  assign w_accept  = mdu_issue_e & ~w_stall_e & ~ex_flush;
  // A branch held in E redirects only once it leaves E.
  assign w_redir   = (pc_src_e != PC_SEQ) & ~w_stall_e;
  assign w_front   = (w_d_stall | w_stall_e) & ~ex_flush;

  mdu_scoreboard #(
    .AW      (REG_AW),
    .TIMEOUT (MDU_TIMEOUT)
  ) u_sb (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_accept   (w_accept),
    .i_set_rd   (rd_e),
    .i_done     (mdu_done),
    .i_done_rd  (mdu_rd_done),
    .i_rs1      (rs1_d),
    .i_rs2      (rs2_d),
    .i_rd       (rd_d),
    .o_pend_rs1 (w_pend_rs1),
    .o_pend_rs2 (w_pend_rs2),
    .o_pend_rd  (w_pend_rd),
    .o_busy     (w_busy),
    .o_timeout  (mdu_timeout)
  );

  assign mdu_busy = w_busy;

  always_comb begin
    stall_f1    = ~reset & w_front;
    stall_f2    = ~reset & w_front;
    stall_d     = ~reset & w_front;
    stall_e     = ~reset & w_stall_e;
    flush_f2    = reset | w_redir | ex_flush;
    flush_d     = reset | w_redir | ex_flush;
    flush_e     = reset | (w_d_stall & ~w_stall_e) | w_redir
                  | ex_flush;
    flush_m     = {(NUM_FWD-1){reset | ex_flush}};
    // Bubble into M1 while E holds its MDU op.
    flush_m[0]  = reset | w_stall_e | ex_flush;
    forward_a_e = reset ? '0 : w_fwd_a;
    forward_b_e = reset ? '0 : w_fwd_b;
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with NUM_FWD=3,
// LOAD_READY=2, MDU_TIMEOUT=8.
module tb_hazard_scoreboard_unit;

  localparam int NF = 3;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, mdu_rd_done;
  logic regwrite_d, load_e, mdu_issue_e, ex_flush, mdu_done;
  logic [NF*AW-1:0] rd_fwd;
  logic [NF-1:0] regwrite_fwd, load_fwd;
  logic [1:0] pc_src_e;
  logic stall_f1, stall_f2, stall_d, stall_e;
  logic flush_f2, flush_d, flush_e;
  logic [NF-2:0] flush_m;
  logic [1:0] forward_a_e, forward_b_e;
  logic mdu_busy, mdu_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .NUM_FWD(NF), .LOAD_READY(2), .REG_AW(AW), .MDU_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .mdu_issue_e(mdu_issue_e),
    .rd_fwd(rd_fwd), .regwrite_fwd(regwrite_fwd),
    .load_fwd(load_fwd), .pc_src_e(pc_src_e),
    .ex_flush(ex_flush), .mdu_done(mdu_done),
    .mdu_rd_done(mdu_rd_done),
    .stall_f1(stall_f1), .stall_f2(stall_f2),
    .stall_d(stall_d), .stall_e(stall_e),
    .flush_f2(flush_f2), .flush_d(flush_d), .flush_e(flush_e),
    .flush_m(flush_m),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rd_d = '0; regwrite_d = 1'b0;
    rs1_e = '0; rs2_e = '0; rd_e = '0;
    load_e = 1'b0; mdu_issue_e = 1'b0;
    rd_fwd = '0; regwrite_fwd = '0; load_fwd = '0;
    pc_src_e = 2'b00; ex_flush = 1'b0;
    mdu_done = 1'b0; mdu_rd_done = '0;
  endtask

  // Advance one clock; inputs change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    settle();
    chk("rst_stall_d", 32'(stall_d), 32'd0);
    chk("rst_flush_d", 32'(flush_d), 32'd1);
    chk("rst_flush_e", 32'(flush_e), 32'd1);
    chk("rst_flush_m", 32'(flush_m), 32'b11);
    reset = 1'b0;
    step();
    settle();
    chk("post_rst_busy", 32'(mdu_busy), 32'd0);
    chk("post_rst_to", 32'(mdu_timeout), 32'd0);
    chk("post_rst_flush_d", 32'(flush_d), 32'd0);

    // Forward priority: M1=x5, M2=x6, W=x5
    rs1_e = 5'd5; rs2_e = 5'd6;
    rd_fwd = {5'd5, 5'd6, 5'd5}; regwrite_fwd = 3'b111;
    settle();
    chk("fwd_a_near", 32'(forward_a_e), 32'd1);
    chk("fwd_b_m2", 32'(forward_b_e), 32'd2);
    rs1_e = 5'd0;
    settle();
    chk("fwd_a_x0", 32'(forward_a_e), 32'd0);
    rs1_e = 5'd5; rd_fwd = {5'd5, 5'd0, 5'd0}; regwrite_fwd = 3'b100;
    settle();
    chk("fwd_a_w", 32'(forward_a_e), 32'd3);
    regwrite_fwd = 3'b000;
    settle();
    chk("fwd_a_nowe", 32'(forward_a_e), 32'd0);

    // Load-use
    idle();
    load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    settle();
    chk("ld_e_stall_d", 32'(stall_d), 32'd1);
    chk("ld_e_stall_f1", 32'(stall_f1), 32'd1);
    chk("ld_e_flush_e", 32'(flush_e), 32'd1);
    chk("ld_e_flush_d", 32'(flush_d), 32'd0);
    step();
    load_e = 1'b0; rd_e = 5'd0;
    rd_fwd = {5'd0, 5'd0, 5'd7}; load_fwd = 3'b001; regwrite_fwd = 3'b001;
    settle();
    chk("ld_m1_stall", 32'(stall_d), 32'd1);
    step();
    rd_fwd = {5'd0, 5'd7, 5'd0}; load_fwd = 3'b010; regwrite_fwd = 3'b010;
    rs2_e = 5'd7;
    settle();
    chk("ld_m2_nostall", 32'(stall_d), 32'd0);
    chk("ld_m2_fwd_b", 32'(forward_b_e), 32'd2);

    // Scoreboard: rd=9 outstanding 20 cycles
    idle();
    mdu_issue_e = 1'b1; rd_e = 5'd9;
    settle();
    chk("issue_no_stall_e", 32'(stall_e), 32'd0);
    step();
    idle();
    rs1_d = 5'd9;
    settle();
    chk("sb_busy", 32'(mdu_busy), 32'd1);
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) begin
        mdu_done = 1'b1; mdu_rd_done = 5'd9;
      end
      settle();
      chk($sformatf("sb_hold_%0d", c), 32'(stall_d), 32'd1);
      step();
    end
    mdu_done = 1'b0;
    settle();
    chk("sb_release", 32'(stall_d), 32'd0);
    chk("sb_idle", 32'(mdu_busy), 32'd0);

    // Structural stall with a branch in E
    idle();
    mdu_issue_e = 1'b1; rd_e = 5'd9;
    step();
    rd_e = 5'd10; pc_src_e = 2'b01;
    settle();
    chk("str_stall_e", 32'(stall_e), 32'd1);
    chk("str_flush_m", 32'(flush_m), 32'b01);
    chk("str_stall_d", 32'(stall_d), 32'd1);
    chk("str_flush_d", 32'(flush_d), 32'd0);
    chk("str_flush_e", 32'(flush_e), 32'd0);
    step();
    settle();
    chk("str_hold", 32'(stall_e), 32'd1);
    mdu_done = 1'b1; mdu_rd_done = 5'd9;
    settle();
    chk("str_go_stall_e", 32'(stall_e), 32'd0);
    chk("str_go_flush_f2", 32'(flush_f2), 32'd1);
    chk("str_go_flush_d", 32'(flush_d), 32'd1);
    chk("str_go_flush_e", 32'(flush_e), 32'd1);
    step();
    idle();
    rs1_d = 5'd10;
    settle();
    chk("b2b_busy", 32'(mdu_busy), 32'd1);
    chk("b2b_pend10", 32'(stall_d), 32'd1);
    rs1_d = 5'd9;
    settle();
    chk("b2b_clr9", 32'(stall_d), 32'd0);

    // ex_flush with x10 outstanding
    rs1_d = 5'd10; ex_flush = 1'b1; mdu_issue_e = 1'b1; rd_e = 5'd11;
    settle();
    chk("exf_stall_d", 32'(stall_d), 32'd0);
    chk("exf_stall_e", 32'(stall_e), 32'd0);
    chk("exf_flush_d", 32'(flush_d), 32'd1);
    chk("exf_flush_e", 32'(flush_e), 32'd1);
    chk("exf_flush_m", 32'(flush_m), 32'b11);
    step();
    idle();
    rs1_d = 5'd10;
    settle();
    chk("exf_keep10", 32'(stall_d), 32'd1);
    rs1_d = 5'd11;
    settle();
    chk("exf_no11", 32'(stall_d), 32'd0);
    rs1_d = 5'd0; regwrite_d = 1'b1; rd_d = 5'd10;
    settle();
    chk("waw_stall", 32'(stall_d), 32'd1);
    regwrite_d = 1'b0;
    settle();
    chk("waw_nowe", 32'(stall_d), 32'd0);
    mdu_done = 1'b1; mdu_rd_done = 5'd10;
    step();
    idle();
    rs1_d = 5'd10;
    settle();
    chk("exf_done_clr", 32'(stall_d), 32'd0);
    chk("exf_done_idle", 32'(mdu_busy), 32'd0);
    chk("to_sticky", 32'(mdu_timeout), 32'd1);

    // Reset mid-op
    idle();
    mdu_issue_e = 1'b1; rd_e = 5'd12;
    step();
    idle();
    reset = 1'b1; rs1_d = 5'd12;
    settle();
    chk("rst_mid_stall", 32'(stall_d), 32'd0);
    chk("rst_mid_flush_f2", 32'(flush_f2), 32'd1);
    step();
    reset = 1'b0;
    settle();
    chk("rst_mid_busy", 32'(mdu_busy), 32'd0);
    chk("rst_mid_to", 32'(mdu_timeout), 32'd0);
    chk("rst_mid_pend", 32'(stall_d), 32'd0);
    mdu_done = 1'b1; mdu_rd_done = 5'd12;
    step();
    mdu_done = 1'b0;
    settle();
    chk("stale_done", 32'(mdu_busy), 32'd0);

    // Watchdog: flag in 8th busy cycle, then sticky
    idle();
    mdu_issue_e = 1'b1; rd_e = 5'd3;
    step();
    idle();
    for (int n = 1; n <= 11; n++) begin
      settle();
      chk($sformatf("wd_%0d", n), 32'(mdu_timeout),
          (n >= 8) ? 32'd1 : 32'd0);
      step();
    end
    mdu_done = 1'b1; mdu_rd_done = 5'd3;
    step();
    idle();
    settle();
    chk("wd_after_done", 32'(mdu_timeout), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("wd_reset", 32'(mdu_timeout), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the fixed five-stage-plus-M2 hazard logic.
- Handles a configurable number of forwarding stages after E and a configurable load-ready point.
- Adds a sequential scoreboard for a single-outstanding multi-cycle MDU (mul/div), including a timeout watchdog.
- Sits beside the pipeline registers. Drives all stall, flush and forward-select controls for the F1/F2/D/E/M*/W pipeline.

Parameters:
- NUM_FWD, default 3: forwarding stages after E (index 1 = M1 ... NUM_FWD = W).
- LOAD_READY, default 2: first fwd-stage index whose load data can be forwarded; loads in E or in fwd stages < LOAD_READY force a D stall.
- REG_AW, default 5: register address width.
- MDU_TIMEOUT, default 64: cycles an MDU op may stay pending before an error is flagged.
- SEL_W, default $clog2(NUM_FWD+1): forward-select width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rs1_d, rs2_d, rd_d  in  REG_AW each  D-stage source/dest regs
- regwrite_d  in  1  D instruction writes rd_d
- rs1_e, rs2_e, rd_e  in  REG_AW each  E-stage regs
- load_e  in  1  E instruction is a load
- mdu_issue_e  in  1  E instruction is an MDU op
- rd_fwd  in  NUM_FWD*REG_AW  packed dest regs; stage k occupies slice k-1
- regwrite_fwd  in  NUM_FWD  per-stage write enable
- load_fwd  in  NUM_FWD  per-stage "instruction is a load"
- pc_src_e  in  2  nonzero = redirect from E
- ex_flush  in  1  exception/trap flush
- mdu_done  in  1  MDU result written back this cycle
- mdu_rd_done  in  REG_AW  destination of the completing MDU op
- stall_f1, stall_f2, stall_d, stall_e  out  1 each
- flush_f2, flush_d, flush_e  out  1 each
- flush_m  out  NUM_FWD-1  flushes for M1..M(NUM_FWD-1)
- forward_a_e, forward_b_e  out  SEL_W each  0 = regfile, k = stage k
- mdu_busy  out  1  an MDU op is outstanding
- mdu_timeout  out  1  sticky error flag

Behaviour:
- Forwarding (combinational):
  - forward_a_e = smallest k with rd_fwd[k]==rs1_e, regwrite_fwd[k]=1 and rs1_e!=0; else 0. Nearest stage wins.
  - forward_b_e uses rs2_e with the same rule.
- Load-use stall, ld_stall:
  - Asserted when load_e and rd_e!=0 and rd_e matches rs1_d or rs2_d.
  - Also asserted for any k<LOAD_READY with load_fwd[k], regwrite_fwd[k], rd_fwd[k]!=0 and rd_fwd[k] matching rs1_d or rs2_d.
- Scoreboard state:
  - pending: 2^REG_AW bit register; bit 0 is always 0.
  - mdu_busy register.
  - wd_cnt: counter of width $clog2(MDU_TIMEOUT+1).
- Scoreboard stall, sb_stall: asserted when pending[rs1_d] or pending[rs2_d], or (regwrite_d and pending[rd_d]) for WAW.
- MDU structural stall:
  - stall_e = mdu_issue_e & mdu_busy & ~mdu_done & ~ex_flush.
  - The op is accepted (accept) when mdu_issue_e & ~stall_e & ~ex_flush.
- Accept:
  - Sets mdu_busy and pending[rd_e] (only if rd_e!=0), and clears wd_cnt. All take effect next cycle.
- mdu_done:
  - Clears pending[mdu_rd_done] and mdu_busy.
  - If accept happens in the same cycle: a back-to-back op is allowed. Set wins on an equal register, and mdu_busy stays 1.
  - A mdu_done while not busy is ignored, with no state change.
- ex_flush:
  - Kills only younger instructions.
  - The outstanding MDU op is older, so pending and mdu_busy are preserved.
- Watchdog:
  - wd_cnt increments while mdu_busy, saturating at MDU_TIMEOUT.
  - Reaching MDU_TIMEOUT sets mdu_timeout, which is sticky until reset.
- Front-end stalls:
  - Let d_stall = ld_stall | sb_stall.
  - stall_f1 = stall_f2 = stall_d = (d_stall | stall_e) & ~ex_flush.
- Redirect: redir = |pc_src_e & ~stall_e. A stalled branch redirects later, when it leaves E.
- Flushes:
  - flush_f2 = flush_d = redir | ex_flush.
  - flush_e = (d_stall & ~stall_e) | redir | ex_flush.
  - flush_m[0] = stall_e | ex_flush, which puts a bubble into M1 while E holds.
  - flush_m[k>0] = ex_flush.
- Reset (synchronous, active-high):
  - State: pending=0, mdu_busy=0, wd_cnt=0, mdu_timeout=0.
  - While reset is high: all stalls=0, all flushes=1, forwards=0.
  - Reset mid-MDU-op discards the op. A later mdu_done is then ignored.

Decomposition:
- Shared package pipe_hazard_pkg holds:
  - REG_AW;
  - the FWD_REGFILE=0 select constant;
  - the PC_SRC encoding (00 seq, 01 branch, 10 jalr);
  - a function for nearest-stage match priority.
- One natural sub-module, mdu_scoreboard, contains pending, mdu_busy and the watchdog.
  - Inputs: set/clear/reg addresses.
  - Outputs: pending lookups for rs1_d, rs2_d and rd_d, plus mdu_busy and mdu_timeout.
- The top level keeps the forwarding and stall/flush logic.

Test Plan:
- Forward priority: rs1_e=5; M1 and W both write x5; M2 writes x6 -> forward_a_e=1.
  - Same with rs1_e=0 -> forward_a_e=0.
- Load-use, LOAD_READY=2:
  - load_e with rd_e=7 and rs2_d=7 -> stall_f1/f2/d=1 and flush_e=1 for one cycle.
  - With the load in M1 next cycle -> stall again.
  - With the load in M2 -> no stall, forward_b_e=2.
- Scoreboard:
  - MDU issue rd_e=9 -> mdu_busy=1.
  - rs1_d=9 -> stall_d held for 20 cycles until mdu_done with mdu_rd_done=9; released the next cycle.
  - regwrite_d with rd_d=9 while pending -> stall (WAW).
- Structural stall:
  - Second MDU op in E while busy -> stall_e=1, flush_m[0]=1, stall_d=1.
  - Same cycle pc_src_e=01 -> flush_d=0 until stall_e drops, then flush_f2/d/e=1.
- ex_flush with mdu_busy -> all stalls=0, flushes=1, pending[rd] is retained.
  - mdu_done after ex_flush clears the pending bit.
- Watchdog and reset:
  - MDU_TIMEOUT=8 with no mdu_done -> mdu_timeout=1 in the 8th busy cycle and stays set.
  - reset=1 for one cycle -> pending=0, mdu_busy=0, mdu_timeout=0, flushes=1 during reset.
